// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data_memory line store.
package dmem_pkg;

  localparam int LINE_W          = 256;
  localparam int ADDR_W          = 32;
  localparam int OFF_LSB         = 0;
  localparam int OFF_MSB         = 4;
  localparam int IDX_LSB         = 5;
  localparam int IDX_MSB         = 13;
  localparam int DEFAULT_LATENCY = 10;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

  // The counter reaches 0 on the edge that enters ACK, so it is loaded with LATENCY-1.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage with one synchronous port; only the read register is reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned IDX_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Holds the last line read; writes never touch it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Fixed-latency line memory for a cache controller: one request in flight, one-cycle ack.
// Optional DATA_MEMORY_STATS_EN adds saturating read/write completion counters.
//
// state | meaning
// IDLE  | waiting for enable_i; accepts and latches a request
// WAIT  | counting down; array is accessed on the edge the count reaches 0
// ACK   | ack_o high for one cycle, always returns to IDLE
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = DEFAULT_LATENCY,
  parameter int unsigned DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef DATA_MEMORY_STATS_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(LATENCY);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              write_q, write_d;

  logic              arr_en, arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [LINE_W-1:0] arr_wdata;
  logic [IDX_W-1:0]  idx_in;
  logic              unused_addr_bits;

  assign idx_in           = addr_i[IDX_LSB +: IDX_W];
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:IDX_LSB+IDX_W], addr_i[IDX_LSB-1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_idx   = addr_q;
    arr_wdata = data_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          addr_d  = idx_in;
          data_d  = data_i;
          write_d = write_i;
          cnt_d   = LAT_LOAD;
          // Single-cycle latency: the access happens on the accepting edge itself.
          if (LATENCY == 1) begin
            state_d   = ACK;
            arr_en    = 1'b1;
            arr_we    = write_i;
            arr_idx   = idx_in;
            arr_wdata = data_i;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
          arr_en  = 1'b1;
          arr_we  = write_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  dmem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (data_o)
  );

  assign ack_o = (state_q == ACK);

`ifdef DATA_MEMORY_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == ACK) begin
      if (write_q) begin
        if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
